branch_resolver: RTL and testbench

//  Execute-stage consumer of branch/compare ops: registers one decoded op, evaluates the condition
//  (beq/bne/blt/bge/bltu/bgeu; slt/sltu pass-through), computes target and link, checks the fetch prediction.
//  On mispredict it raises a redirect to fetch and holds it until accepted, stalling upstream meanwhile.

---
 rtl/branch_resolver_pkg.sv | 24 ++
 rtl/branch_resolver_cmp.sv | 34 +++
 rtl/branch_resolver.sv | 129 ++++++++++++
 tb/tb_branch_resolver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: condition codes, op kinds and FSM states.
package branch_resolver_pkg;

   // Condition codes follow the RISC-V funct3 layout so decode can pass them through.
   localparam logic [2:0] FuncBeq  = 3'd0;
   localparam logic [2:0] FuncBne  = 3'd1;
   localparam logic [2:0] FuncSlt  = 3'd2;
   localparam logic [2:0] FuncSltu = 3'd3;
   localparam logic [2:0] FuncBlt  = 3'd4;
   localparam logic [2:0] FuncBge  = 3'd5;
   localparam logic [2:0] FuncBltu = 3'd6;
   localparam logic [2:0] FuncBgeu = 3'd7;

   localparam logic [1:0] KindNone = 2'd0;
   localparam logic [1:0] KindBr   = 2'd1;
   localparam logic [1:0] KindJal  = 2'd2;
   localparam logic [1:0] KindJalr = 2'd3;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StRedir = 1'b1
   } br_state_e;

endpackage

// File: rtl/branch_resolver_cmp.sv
// Condition evaluator: equality, signed and unsigned less-than, and their complements.
module branch_resolver_cmp
   import branch_resolver_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic [2:0]       func_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   output logic             comp_o
);

   logic eq, lt, ltu;

   assign eq  = (a_i == b_i);
   assign lt  = ($signed(a_i) < $signed(b_i));
   assign ltu = (a_i < b_i);

   always_comb begin
      comp_o = 1'b0;
      unique case (func_i)
         FuncBeq:  comp_o = eq;
         FuncBne:  comp_o = ~eq;
         FuncBlt:  comp_o = lt;
         FuncBge:  comp_o = ~lt;
         FuncBltu: comp_o = ltu;
         FuncBgeu: comp_o = ~ltu;
         FuncSlt:  comp_o = lt;
         FuncSltu: comp_o = ltu;
         default:  comp_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: registers one op per cycle, checks the fetch prediction
// and holds a redirect to fetch until it is accepted.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_func,
   input  logic [1:0]           in_kind,
   input  logic [WIDTH-1:0]     in_pc,
   input  logic [WIDTH-1:0]     in_rs1,
   input  logic [WIDTH-1:0]     in_rs2,
   input  logic [WIDTH-1:0]     in_imm,
   input  logic                 in_pred_taken,
   input  logic [WIDTH-1:0]     in_pred_pc,
   output logic                 out_valid,
   output logic                 out_taken,
   output logic [WIDTH-1:0]     out_link,
   output logic                 redirect_valid,
   input  logic                 redirect_ready,
   output logic [WIDTH-1:0]     redirect_pc,
   output logic [CNT_WIDTH-1:0] mispredict_cnt
);

   br_state_e            state_q, state_d;
   logic                 out_valid_q, out_taken_q;
   logic [WIDTH-1:0]     out_link_q, redirect_pc_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic             comp, accept, taken, mispredict, res_taken;
   logic [WIDTH-1:0] pc_plus4, br_target, jalr_sum, target, next_pc, res_link;

   branch_resolver_cmp #(
      .Width (WIDTH)
   ) u_cmp (
      .func_i (in_func),
      .a_i    (in_rs1),
      .b_i    (in_rs2),
      .comp_o (comp)
   );

   assign in_ready = (state_q == StRun);
   assign accept   = in_valid & in_ready;

   assign pc_plus4  = in_pc + WIDTH'(4);
   assign br_target = in_pc + in_imm;
   assign jalr_sum  = in_rs1 + in_imm;

   always_comb begin
      taken     = 1'b0;
      target    = br_target;
      res_taken = 1'b0;
      res_link  = pc_plus4;
      unique case (in_kind)
         KindNone: begin
            // Compare ops report their result bit but never redirect as "taken".
            res_taken = comp;
            res_link  = {{(WIDTH-1){1'b0}}, comp};
         end
         KindBr: begin
            taken     = comp;
            res_taken = comp;
         end
         KindJal: begin
            taken     = 1'b1;
            res_taken = 1'b1;
         end
         KindJalr: begin
            taken     = 1'b1;
            target    = {jalr_sum[WIDTH-1:1], 1'b0};
            res_taken = 1'b1;
         end
         default: ;
      endcase
   end

   assign next_pc    = taken ? target : pc_plus4;
   assign mispredict = (in_pred_taken != taken) | (taken & (in_pred_pc != target));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (accept && mispredict) begin
               state_d = StRedir;
               cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            end
         end
         StRedir: begin
            if (redirect_ready) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StRun;
         out_valid_q   <= 1'b0;
         out_taken_q   <= 1'b0;
         out_link_q    <= '0;
         redirect_pc_q <= '0;
         cnt_q         <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= accept;
         if (accept) begin
            out_taken_q <= res_taken;
            out_link_q  <= res_link;
            if (mispredict) redirect_pc_q <= next_pc;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_taken      = out_taken_q;
   assign out_link       = out_link_q;
   assign redirect_valid = (state_q == StRedir);
   assign redirect_pc    = redirect_pc_q;
   assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver; counter narrowed to 4 bits so saturation is reachable.
module tb_branch_resolver;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [2:0]    in_func;
   logic [1:0]    in_kind;
   logic [W-1:0]  in_pc, in_rs1, in_rs2, in_imm, in_pred_pc;
   logic          in_pred_taken;
   logic          out_valid, out_taken;
   logic [W-1:0]  out_link;
   logic          redirect_valid, redirect_ready;
   logic [W-1:0]  redirect_pc;
   logic [CW-1:0] mispredict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolver #(
      .WIDTH     (W),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_func        (in_func),
      .in_kind        (in_kind),
      .in_pc          (in_pc),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_imm         (in_imm),
      .in_pred_taken  (in_pred_taken),
      .in_pred_pc     (in_pred_pc),
      .out_valid      (out_valid),
      .out_taken      (out_taken),
      .out_link       (out_link),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .mispredict_cnt (mispredict_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one op for a single cycle; returns 1ns after the capturing edge.
   task automatic issue(input logic [2:0] func, input logic [1:0] kind, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ppc);
      in_valid      = 1'b1;
      in_func       = func;
      in_kind       = kind;
      in_pc         = pc;
      in_rs1        = rs1;
      in_rs2        = rs2;
      in_imm        = imm;
      in_pred_taken = pt;
      in_pred_pc    = ppc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic accept_redirect();
      redirect_ready = 1'b1;
      @(posedge clk);
      #1;
      redirect_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_func = 3'd0; in_kind = 2'd0; in_pc = '0; in_rs1 = '0;
      in_rs2 = '0; in_imm = '0; in_pred_taken = 1'b0; in_pred_pc = '0; redirect_ready = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_taken", 32'(out_taken), 32'd0);
      check("rst_out_link", out_link, 32'd0);
      check("rst_redir_valid", 32'(redirect_valid), 32'd0);
      check("rst_redir_pc", redirect_pc, 32'd0);
      check("rst_cnt", 32'(mispredict_cnt), 32'd0);
      #9 rst_n = 1'b1;

      // beq taken, correctly predicted
      issue(3'd0, 2'd1, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120);
      check("beq_valid", 32'(out_valid), 32'd1);
      check("beq_taken", 32'(out_taken), 32'd1);
      check("beq_link", out_link, 32'h104);
      check("beq_noredir", 32'(redirect_valid), 32'd0);
      check("beq_cnt", 32'(mispredict_cnt), 32'd0);
      @(posedge clk); #1;
      check("beq_pulse", 32'(out_valid), 32'd0);

      // blt signed: -1 < 1 taken, predicted not taken
      issue(3'd4, 2'd1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h304);
      check("blt_taken", 32'(out_taken), 32'd1);
      check("blt_redir", 32'(redirect_valid), 32'd1);
      check("blt_redir_pc", redirect_pc, 32'h340);
      check("blt_cnt", 32'(mispredict_cnt), 32'd1);
      check("blt_in_ready", 32'(in_ready), 32'd0);
      accept_redirect();
      check("blt_released", 32'(redirect_valid), 32'd0);
      check("blt_ready_back", 32'(in_ready), 32'd1);

      // bltu same operands: not taken, correctly predicted
      issue(3'd6, 2'd1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h304);
      check("bltu_valid", 32'(out_valid), 32'd1);
      check("bltu_taken", 32'(out_taken), 32'd0);
      check("bltu_noredir", 32'(redirect_valid), 32'd0);
      check("bltu_cnt", 32'(mispredict_cnt), 32'd1);

      // jalr target clears bit 0 and mismatches predicted pc
      issue(3'd0, 2'd3, 32'h200, 32'h1003, 32'd0, 32'd4, 1'b1, 32'h1000);
      check("jalr_redir_pc", redirect_pc, 32'h1006);
      check("jalr_link", out_link, 32'h204);
      check("jalr_cnt", 32'(mispredict_cnt), 32'd2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_redir", 32'(redirect_valid), 32'd1);
         check("hold_pc", redirect_pc, 32'h1006);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_no_accept", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
      accept_redirect();
      check("jalr_released", 32'(redirect_valid), 32'd0);

      // slt / sltu pass-through
      issue(3'd2, 2'd0, 32'h400, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 32'h0);
      check("slt_taken", 32'(out_taken), 32'd1);
      check("slt_link", out_link, 32'd1);
      check("slt_noredir", 32'(redirect_valid), 32'd0);
      issue(3'd3, 2'd0, 32'h404, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 32'h0);
      check("sltu_taken", 32'(out_taken), 32'd0);
      check("sltu_link", out_link, 32'd0);

      // jal wraps: 0xFFFFFFFC + 8 = 0x4, link wraps to 0
      issue(3'd0, 2'd2, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1, 32'h4);
      check("wrap_noredir", 32'(redirect_valid), 32'd0);
      check("wrap_link", out_link, 32'd0);
      issue(3'd0, 2'd2, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b0, 32'h0);
      check("wrap_redir_pc", redirect_pc, 32'h4);
      check("wrap_cnt", 32'(mispredict_cnt), 32'd3);
      accept_redirect();

      // bne equal operands predicted taken: redirect to pc+4
      for (int i = 0; i < 12; i++) begin
         issue(3'd1, 2'd1, 32'h500, 32'd7, 32'd7, 32'h10, 1'b1, 32'h510);
         accept_redirect();
      end
      check("sat_reach", 32'(mispredict_cnt), 32'd15);
      issue(3'd1, 2'd1, 32'h500, 32'd7, 32'd7, 32'h10, 1'b1, 32'h510);
      check("sat_hold", 32'(mispredict_cnt), 32'd15);
      check("sat_redir_pc", redirect_pc, 32'h504);
      check("sat_redir", 32'(redirect_valid), 32'd1);

      // async reset while a redirect is pending
      rst_n = 1'b0;
      #1;
      check("arst_redir", 32'(redirect_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_cnt", 32'(mispredict_cnt), 32'd0);
      check("arst_redir_pc", redirect_pc, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // redirect_ready high with no redirect pending has no effect
      redirect_ready = 1'b1;
      issue(3'd5, 2'd1, 32'h600, 32'd1, 32'd1, 32'h8, 1'b1, 32'h608);
      check("bge_taken", 32'(out_taken), 32'd1);
      check("bge_noredir", 32'(redirect_valid), 32'd0);
      issue(3'd7, 2'd1, 32'h608, 32'd1, 32'd2, 32'h8, 1'b1, 32'h610);
      check("bgeu_taken", 32'(out_taken), 32'd0);
      check("bgeu_redir", 32'(redirect_valid), 32'd1);
      check("bgeu_redir_pc", redirect_pc, 32'h60C);
      @(posedge clk); #1;
      check("bgeu_released", 32'(redirect_valid), 32'd0);
      redirect_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
